// File: rtl/cpu_dmem_pkg.sv
// Shared types and constants for the commit-stage data-memory responder.
package cpu_dmem_pkg;

    localparam int DMEM_ADDR_W     = 32;
    localparam int DMEM_DATA_W     = 32;
    localparam int DMEM_BYTE_LANES = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_t;

    // 'byte' is a keyword, so the byte-access flag is called is_byte.
    typedef struct packed {
        logic                   write;
        logic                   is_byte;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/cpu_dmem_array.sv
// Single-port word RAM with per-byte-lane write enables, synchronous write and
// combinational read. The storage array mem[] is also the bench preload backdoor.
module cpu_dmem_array
    import cpu_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                             clock,
    input  logic [DMEM_BYTE_LANES-1:0]       lane_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0]   idx,
    input  logic [DMEM_DATA_W-1:0]           wdata,
    output logic [DMEM_DATA_W-1:0]           rdata
);

    logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

    // NOTE: storage has no reset; clearing a RAM would prevent block-RAM mapping and
    // the contents are defined by software stores or preload, never by reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DMEM_BYTE_LANES; i++) begin
            if (lane_we[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/cpu_dmem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY, load word or store ack.
// Optional CPU_DMEM_ALIGN_CHECK_EN flags misaligned word accesses via rsp_error.
module cpu_dmem_responder
    import cpu_dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (LATENCY < 1) begin : g_chk_latency
        $error("cpu_dmem_responder: LATENCY must be >= 1");
    end
    if (DATA_W != DMEM_DATA_W || ADDR_W != DMEM_ADDR_W) begin : g_chk_width
        $error("cpu_dmem_responder: ADDR_W and DATA_W must be 32");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_chk_depth
        $error("cpu_dmem_responder: DEPTH_WORDS must be a power of two");
    end

    dmem_state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    dmem_req_t req_q;

    logic accept, access, misalign;
    logic [1:0] lane;
    logic [IDX_W-1:0] idx;
    logic [DMEM_BYTE_LANES-1:0] lane_we;
    logic [DATA_W-1:0] wr_word, rd_word, load_data;
    logic [7:0] rd_byte;
    logic addr_unused;

    assign accept    = req_valid && req_ready;
    assign access    = (state == DMEM_WAIT) && (cnt == '0);
    assign rsp_valid = (state == DMEM_RESP);

    assign lane        = req_q.addr[1:0];
    assign idx         = req_q.addr[IDX_W+1:2];
    assign addr_unused = ^req_q.addr[ADDR_W-1:IDX_W+2];

`ifdef CPU_DMEM_ALIGN_CHECK_EN
    assign misalign = !req_q.is_byte && (lane != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Writes happen only on the WAIT->RESP edge and never while reset is asserted.
    assign lane_we = (access && reset && req_q.write && !misalign)
                   ? (req_q.is_byte ? (DMEM_BYTE_LANES'(1) << lane) : '1)
                   : '0;
    assign wr_word = req_q.is_byte ? {DMEM_BYTE_LANES{req_q.wdata[7:0]}} : req_q.wdata;

    cpu_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clock   (clock),
        .lane_we (lane_we),
        .idx     (idx),
        .wdata   (wr_word),
        .rdata   (rd_word)
    );

    assign rd_byte   = rd_word[{lane, 3'b000} +: 8];
    assign load_data = (misalign || req_q.write) ? '0
                     : req_q.is_byte ? {24'b0, rd_byte} : rd_word;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            DMEM_IDLE: if (accept)    state_next = DMEM_WAIT;
            DMEM_WAIT: if (cnt == '0) state_next = DMEM_RESP;
            DMEM_RESP: if (rsp_ready) state_next = DMEM_IDLE;
            default:                  state_next = DMEM_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= DMEM_IDLE;
            cnt       <= '0;
            req_q     <= '0;
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == DMEM_IDLE);
            if (accept) begin
                req_q <= '{write: req_write, is_byte: req_byte, addr: req_addr, wdata: req_wdata};
                cnt   <= CNT_W'(LATENCY - 1);
            end else if (state == DMEM_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access) begin
                rsp_rdata <= load_data;
                rsp_error <= misalign;
            end else if (rsp_valid && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Self-checking bench for cpu_dmem_responder: directed scenarios plus random traffic
// against a word-array reference model.
module tb_cpu_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
`ifdef CPU_DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_byte;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] model_mem [DEPTH];

    cpu_dmem_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    always #5 clock = ~clock;

    function automatic void model_access(input logic wr, input logic by, input logic [31:0] addr,
                                         input logic [31:0] wd, output logic [31:0] rd,
                                         output logic er);
        int unsigned idx = (addr / 4) % DEPTH;
        int unsigned sh  = (addr % 4) * 8;
        rd = 32'h0;
        er = 1'b0;
        if (ALIGN_CHK && !by && (addr % 4) != 0) begin
            er = 1'b1;
            return;
        end
        if (wr) begin
            if (by) model_mem[idx] = (model_mem[idx] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            else    model_mem[idx] = wd;
        end else begin
            rd = by ? ((model_mem[idx] >> sh) & 32'hFF) : model_mem[idx];
        end
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        dut.u_array.mem[idx] = val;
        model_mem[idx]       = val;
    endtask

    // Drives one request and returns what was observed; called at a negedge, returns at a negedge.
    task automatic do_txn(input logic wr, input logic by, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall,
                          output logic [31:0] rd, output logic er, output int lat,
                          output bit stable, output bit ready_low, output logic ready_after);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (req_ready !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL txn_ready_timeout: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_byte = by; req_addr = addr; req_wdata = wd;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0; req_write = 1'($urandom); req_byte = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; stable = 1'b1; ready_low = 1'b1;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            if (req_ready !== 1'b0) ready_low = 1'b0;
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        if (rsp_valid !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL txn_rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
        rd = rsp_rdata;
        er = rsp_error;
        repeat (stall) begin
            if (req_ready !== 1'b0) ready_low = 1'b0;
            @(posedge clock);
            @(negedge clock);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_error !== er) stable = 1'b0;
        end
        if (req_ready !== 1'b0) ready_low = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready   = 1'b0;
        ready_after = req_ready;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
            tests_run++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold: req_ready=%b rsp_valid=%b required 0 0", req_ready, rsp_valid);
            end
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_word_store_load;
        logic [31:0] rd, exp_rd; logic er, exp_er; int lat; bit st, rl; logic ra;
        do_txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, st, rl, ra);
        model_access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, exp_rd, exp_er);
        tests_run++;
        if (lat != LAT || rd !== 32'h0 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL word_store: lat=%0d rdata=%h err=%b required %0d 00000000 0", lat, rd, er, LAT);
        end
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 0, rd, er, lat, st, rl, ra);
        model_access(1'b0, 1'b0, 32'h10, 32'h0, exp_rd, exp_er);
        tests_run++;
        if (lat != LAT || rd !== 32'hDEADBEEF || rd !== exp_rd) begin
            tests_failed++;
            $display("FAIL word_load: lat=%0d rdata=%h required %0d deadbeef", lat, rd, LAT);
        end
    endtask

    task automatic test_byte;
        logic [31:0] rd, exp_rd; logic er, exp_er; int lat; bit st, rl; logic ra;
        preload(4, 32'h11223344);
        do_txn(1'b1, 1'b1, 32'h13, 32'h123456AA, 0, rd, er, lat, st, rl, ra);
        model_access(1'b1, 1'b1, 32'h13, 32'h123456AA, exp_rd, exp_er);
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 0, rd, er, lat, st, rl, ra);
        tests_run++;
        if (rd !== 32'hAA223344) begin
            tests_failed++;
            $display("FAIL byte_store_word_load: rdata=%h required aa223344", rd);
        end
        do_txn(1'b0, 1'b1, 32'h13, 32'h0, 0, rd, er, lat, st, rl, ra);
        tests_run++;
        if (rd !== 32'h000000AA) begin
            tests_failed++;
            $display("FAIL byte_load_lane3: rdata=%h required 000000aa", rd);
        end
        do_txn(1'b0, 1'b1, 32'h11, 32'h0, 0, rd, er, lat, st, rl, ra);
        tests_run++;
        if (rd !== 32'h00000033) begin
            tests_failed++;
            $display("FAIL byte_load_lane1: rdata=%h required 00000033", rd);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic er; int lat; bit st, rl; logic ra;
        preload(7, 32'h0BADF00D);
        do_txn(1'b0, 1'b0, 32'h1C, 32'h0, 5, rd, er, lat, st, rl, ra);
        tests_run++;
        if (!st || !rl || rd !== 32'h0BADF00D) begin
            tests_failed++;
            $display("FAIL backpressure_hold: stable=%0d ready_low=%0d rdata=%h required 1 1 0badf00d", st, rl, rd);
        end
        tests_run++;
        if (ra !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_release: req_ready=%b rsp_valid=%b required 1 0", ra, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd; logic er; int lat; bit st, rl; logic ra;
        preload(8, 32'h5);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: rsp_valid=%b req_ready=%b required 0 0", rsp_valid, req_ready);
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        do_txn(1'b0, 1'b0, 32'h20, 32'h0, 0, rd, er, lat, st, rl, ra);
        tests_run++;
        if (rd !== 32'h5 || rd !== model_mem[8]) begin
            tests_failed++;
            $display("FAIL reset_mid_wait_no_write: rdata=%h required 00000005", rd);
        end
    endtask

    task automatic test_wrap_misalign;
        logic [31:0] rd, exp_rd; logic er, exp_er; int lat; bit st, rl; logic ra;
        preload(4, 32'hCAFEF00D);
        do_txn(1'b0, 1'b0, 32'h1010, 32'h0, 0, rd, er, lat, st, rl, ra);
        tests_run++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL addr_wrap: rdata=%h err=%b required cafef00d 0", rd, er);
        end
        do_txn(1'b0, 1'b0, 32'h11, 32'h0, 1, rd, er, lat, st, rl, ra);
        model_access(1'b0, 1'b0, 32'h11, 32'h0, exp_rd, exp_er);
        tests_run++;
        if (rd !== exp_rd || er !== exp_er || lat != LAT) begin
            tests_failed++;
            $display("FAIL misalign_load: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, exp_rd, exp_er, LAT);
        end
        do_txn(1'b1, 1'b0, 32'h12, 32'h76543210, 0, rd, er, lat, st, rl, ra);
        model_access(1'b1, 1'b0, 32'h12, 32'h76543210, exp_rd, exp_er);
        tests_run++;
        if (rd !== 32'h0 || er !== exp_er) begin
            tests_failed++;
            $display("FAIL misalign_store_rsp: rdata=%h err=%b required 00000000 %b", rd, er, exp_er);
        end
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 0, rd, er, lat, st, rl, ra);
        tests_run++;
        if (rd !== model_mem[4]) begin
            tests_failed++;
            $display("FAIL misalign_store_effect: rdata=%h required %h", rd, model_mem[4]);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, exp_rd, addr, wd; logic er, exp_er, wr, by; int lat; bit st, rl; logic ra;
        for (int i = 0; i < 60; i++) begin
            wr   = 1'($urandom);
            by   = 1'($urandom);
            addr = $urandom;
            wd   = $urandom;
            do_txn(wr, by, addr, wd, int'($urandom_range(0, 2)), rd, er, lat, st, rl, ra);
            model_access(wr, by, addr, wd, exp_rd, exp_er);
            tests_run++;
            if (rd !== exp_rd || er !== exp_er || lat != LAT || !st || !rl || ra !== 1'b1) begin
                tests_failed++;
                $display("FAIL random_%0d: wr=%b byte=%b addr=%h rdata=%h err=%b lat=%0d st=%0d rl=%0d ra=%b required rdata=%h err=%b lat=%0d",
                         i, wr, by, addr, rd, er, lat, st, rl, ra, exp_rd, exp_er, LAT);
            end
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        @(negedge clock);
        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
        test_reset;
        test_word_store_load;
        test_byte;
        test_backpressure;
        test_reset_mid_wait;
        test_wrap_misalign;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
